// File: rtl/axi_txn_launcher_if.sv
// Bundle between axi_txn_launcher and its controller/consumer: run control,
// axi_full_top completion feedback, and the launch pulse/status outputs.
interface axi_txn_launcher_if #(
  parameter int unsigned CNT_W = 8
);
  logic             START;
  logic             TXN_DONE;
  logic             TXN_ERROR;
  logic             INIT_AXI_TXN;
  logic             BUSY;
  logic             ALL_DONE;
  logic             FAIL;
  logic             TIMEOUT;
  logic [CNT_W-1:0] TXN_COUNT;

  modport master (
    input  START, TXN_DONE, TXN_ERROR,
    output INIT_AXI_TXN, BUSY, ALL_DONE, FAIL, TIMEOUT, TXN_COUNT
  );

  modport slave (
    output START, TXN_DONE, TXN_ERROR,
    input  INIT_AXI_TXN, BUSY, ALL_DONE, FAIL, TIMEOUT, TXN_COUNT
  );
endinterface

// File: rtl/axi_txn_launcher.sv
// Launches NUM_TXN INIT_AXI_TXN pulses toward axi_full_top per START and gathers
// a pass/fail result. Define TXN_TIMEOUT_EN to add the per-transaction watchdog.
module axi_txn_launcher #(
  parameter int unsigned NUM_TXN        = 4,
  parameter int unsigned INIT_PULSE_W   = 2,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             AXI_ACLK,
  input  logic             AXI_ARESETN,
  axi_txn_launcher_if.master bus
);

  localparam int unsigned PW = $clog2(INIT_PULSE_W + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           r_state,  w_state;
  logic [PW-1:0]    r_pcnt,   w_pcnt;
  logic [GW-1:0]    r_gcnt,   w_gcnt;
  logic [CNT_W-1:0] r_cnt,    w_cnt;
  logic             r_init,   w_init;
  logic             r_busy,   w_busy;
  logic             r_all,    w_all;
  logic             r_fail,   w_fail;
  logic             r_done_q;
  logic             w_done_edge;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef TXN_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0]    r_wdog,   w_wdog;
  logic             r_to,     w_to;
`endif

  assign w_done_edge = bus.TXN_DONE & ~r_done_q;
  assign w_cnt_inc   = r_cnt + 1'b1;

  always_comb begin
    w_state = r_state;
    w_pcnt  = r_pcnt;
    w_gcnt  = r_gcnt;
    w_cnt   = r_cnt;
    w_init  = r_init;
    w_busy  = r_busy;
    w_all   = r_all;
    w_fail  = r_fail;
`ifdef TXN_TIMEOUT_EN
    w_wdog  = r_wdog;
    w_to    = r_to;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_state = S_PULSE;
          w_init  = 1'b1;
          w_pcnt  = PW'(1);
          w_busy  = 1'b1;
          w_all   = 1'b0;
          w_fail  = 1'b0;
          w_cnt   = '0;
`ifdef TXN_TIMEOUT_EN
          w_to    = 1'b0;
`endif
        end
      end
      S_PULSE: begin
        // r_pcnt already counts the cycle in which the pulse went high
        if (r_pcnt == PW'(INIT_PULSE_W)) begin
          w_state = S_WAIT_DONE;
          w_init  = 1'b0;
`ifdef TXN_TIMEOUT_EN
          w_wdog  = '0;
`endif
        end else begin
          w_pcnt = r_pcnt + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (w_done_edge) begin
          w_cnt = w_cnt_inc;
          if (bus.TXN_ERROR) w_fail = 1'b1;
          if (w_cnt_inc == CNT_W'(NUM_TXN)) begin
            w_state = S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            w_state = S_PULSE;
            w_init  = 1'b1;
            w_pcnt  = PW'(1);
          end else begin
            w_state = S_GAP;
            w_gcnt  = '0;
          end
        end
`ifdef TXN_TIMEOUT_EN
        // A completion in the expiry cycle takes priority over the timeout
        else if (r_wdog == WW'(TIMEOUT_CYCLES - 1)) begin
          w_to    = 1'b1;
          w_fail  = 1'b1;
          w_state = S_FINISH;
        end else begin
          w_wdog = r_wdog + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (r_gcnt == GW'(GAP_CYCLES)) begin
          w_state = S_PULSE;
          w_init  = 1'b1;
          w_pcnt  = PW'(1);
        end else begin
          w_gcnt = r_gcnt + 1'b1;
        end
      end
      S_FINISH: begin
        w_all   = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_state  <= S_IDLE;
      r_pcnt   <= '0;
      r_gcnt   <= '0;
      r_cnt    <= '0;
      r_init   <= 1'b0;
      r_busy   <= 1'b0;
      r_all    <= 1'b0;
      r_fail   <= 1'b0;
      r_done_q <= 1'b0;
`ifdef TXN_TIMEOUT_EN
      r_wdog   <= '0;
      r_to     <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_pcnt   <= w_pcnt;
      r_gcnt   <= w_gcnt;
      r_cnt    <= w_cnt;
      r_init   <= w_init;
      r_busy   <= w_busy;
      r_all    <= w_all;
      r_fail   <= w_fail;
      r_done_q <= bus.TXN_DONE;
`ifdef TXN_TIMEOUT_EN
      r_wdog   <= w_wdog;
      r_to     <= w_to;
`endif
    end
  end

  assign bus.INIT_AXI_TXN = r_init;
  assign bus.BUSY         = r_busy;
  assign bus.ALL_DONE     = r_all;
  assign bus.FAIL         = r_fail;
  assign bus.TXN_COUNT    = r_cnt;
`ifdef TXN_TIMEOUT_EN
  assign bus.TIMEOUT      = r_to;
`else
  assign bus.TIMEOUT      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_txn_launcher.sv
// Bench for axi_txn_launcher: randomized completion timing and errors, checked
// against launch/completion timing rules evaluated on recorded edge indices.
module tb_axi_txn_launcher;

  localparam int NUM = 4;
  localparam int PW  = 2;
  localparam int GAP = 16;
  localparam int CW  = 8;
`ifdef TXN_TIMEOUT_EN
  localparam int MAXD  = 50;
  localparam int NOM_D = 50;
`else
  localparam int MAXD  = 120;
  localparam int NOM_D = 100;
`endif

  logic AXI_ACLK = 1'b0;
  logic AXI_ARESETN;
  always #5 AXI_ACLK = ~AXI_ACLK;

  axi_txn_launcher_if #(.CNT_W(CW)) bus ();

  axi_txn_launcher #(
    .NUM_TXN(NUM), .INIT_PULSE_W(PW), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(64), .CNT_W(CW)
  ) dut (
    .AXI_ACLK(AXI_ACLK),
    .AXI_ARESETN(AXI_ARESETN),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int ecyc  = 0;
  bit spam  = 1'b0;

  always @(posedge AXI_ACLK) ecyc <= ecyc + 1;

  // recorded observations of one run (edge indices and sampled values)
  int m_rise[NUM], m_width[NUM], m_fall[NUM], m_done[NUM], m_cnt[NUM], m_hold[NUM];
  int m_launch, m_start, m_pre_all, m_pre_busy;
  int f_all, f_busy, f_fail, f_to, f_cnt;

  task automatic step();
    @(posedge AXI_ACLK);
    #1;
    if (spam) bus.START = 1'($urandom_range(0, 1));
  endtask

  // Plays axi_full_top: answers each launch with a TXN_DONE rise after a delay.
  task automatic drive_run(input int err_mask, input bit sticky, input bit do_spam,
                           input int dly_fixed, input int stall_idx);
    int budget;
    int d;
    int w;
    m_launch = 0;
    for (int i = 0; i < NUM; i++) begin
      m_rise[i] = -1; m_width[i] = -1; m_done[i] = -1; m_cnt[i] = -1; m_hold[i] = -1;
    end
    if (sticky) bus.TXN_DONE = 1'b1;
    bus.START = 1'b1;
    step();
    m_start = ecyc;
    bus.START = 1'b0;
    spam = do_spam;
    for (int i = 0; i < NUM; i++) begin
      budget = GAP + 8;
      while (!bus.INIT_AXI_TXN && budget > 0) begin
        step();
        budget--;
      end
      if (!bus.INIT_AXI_TXN) break;
      m_rise[i] = ecyc;
      m_launch++;
      w = 0;
      while (bus.INIT_AXI_TXN && w < 64) begin
        step();
        w++;
      end
      m_width[i] = w;
      m_fall[i]  = ecyc;
      if (i == stall_idx) begin
        spam = 1'b0;
        bus.START = 1'b0;
        return;
      end
      if (sticky) begin
        repeat (3) begin
          bus.TXN_ERROR = 1'($urandom_range(0, 1));
          step();
        end
        m_hold[i] = int'(bus.TXN_COUNT);
        bus.TXN_DONE = 1'b0;
        step();
      end
      d = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, MAXD));
      repeat (d) begin
        bus.TXN_ERROR = 1'($urandom_range(0, 1));
        step();
      end
      bus.TXN_DONE  = 1'b1;
      bus.TXN_ERROR = 1'(err_mask >> i);
      step();
      m_done[i] = ecyc;
      m_cnt[i]  = int'(bus.TXN_COUNT);
      bus.TXN_ERROR = 1'b0;
      if (!sticky) bus.TXN_DONE = 1'b0;
      if (i == NUM - 1) begin
        spam = 1'b0;
        bus.START = 1'b0;
      end
    end
    spam = 1'b0;
    bus.START = 1'b0;
    m_pre_all  = int'(bus.ALL_DONE);
    m_pre_busy = int'(bus.BUSY);
    step();
    f_all  = int'(bus.ALL_DONE);
    f_busy = int'(bus.BUSY);
    f_fail = int'(bus.FAIL);
    f_to   = int'(bus.TIMEOUT);
    f_cnt  = int'(bus.TXN_COUNT);
    bus.TXN_DONE = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [CW+4:0] outs;
    AXI_ARESETN   = 1'b0;
    bus.START     = 1'b0;
    bus.TXN_DONE  = 1'b0;
    bus.TXN_ERROR = 1'b0;
    repeat (25) step();
    outs = {bus.INIT_AXI_TXN, bus.BUSY, bus.ALL_DONE, bus.FAIL, bus.TIMEOUT, bus.TXN_COUNT};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    #2 AXI_ARESETN = 1'b1;
    repeat (3) step();
    total++;
    if ({bus.INIT_AXI_TXN, bus.BUSY} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=00", {bus.INIT_AXI_TXN, bus.BUSY});
    end
  endtask

  task automatic test_runs();
    int masks[5];
    int stick[5];
    int spams[5];
    int dlys[5];
    int exp_rise;
    masks = '{0, 4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0};
    stick = '{0, 0, 0, 0, 1};
    spams = '{0, 0, 0, 0, 1};
    dlys  = '{NOM_D, -1, -1, -1, -1};
    for (int s = 0; s < 5; s++) begin
      drive_run(masks[s], stick[s] != 0, spams[s] != 0, dlys[s], -1);
      total++;
      if (m_launch !== NUM) begin
        bad++;
        $display("FAIL s%0d_launches got=%0d want=%0d", s, m_launch, NUM);
      end
      for (int i = 0; i < NUM; i++) begin
        if (i == 0)        exp_rise = m_start;
        else if (GAP == 0) exp_rise = m_done[i-1];
        else               exp_rise = m_done[i-1] + 1 + GAP;
        total++;
        if (m_rise[i] !== exp_rise) begin
          bad++;
          $display("FAIL s%0d_rise%0d got=%0d want=%0d", s, i, m_rise[i], exp_rise);
        end
        total++;
        if (m_width[i] !== PW) begin
          bad++;
          $display("FAIL s%0d_width%0d got=%0d want=%0d", s, i, m_width[i], PW);
        end
        total++;
        if (m_cnt[i] !== i + 1) begin
          bad++;
          $display("FAIL s%0d_count%0d got=%0d want=%0d", s, i, m_cnt[i], i + 1);
        end
        if (stick[s] != 0) begin
          total++;
          if (m_hold[i] !== i) begin
            bad++;
            $display("FAIL s%0d_held_done%0d got=%0d want=%0d", s, i, m_hold[i], i);
          end
        end
      end
      total++;
      if ({m_pre_all, m_pre_busy} !== {32'd0, 32'd1}) begin
        bad++;
        $display("FAIL s%0d_finish_cycle got=all%0d/busy%0d want=all0/busy1", s, m_pre_all, m_pre_busy);
      end
      total++;
      if (f_all !== 1 || f_busy !== 0) begin
        bad++;
        $display("FAIL s%0d_done_flags got=all%0d/busy%0d want=all1/busy0", s, f_all, f_busy);
      end
      total++;
      if (f_cnt !== NUM) begin
        bad++;
        $display("FAIL s%0d_final_count got=%0d want=%0d", s, f_cnt, NUM);
      end
      total++;
      if (f_fail !== int'(masks[s] != 0)) begin
        bad++;
        $display("FAIL s%0d_fail got=%0d want=%0d", s, f_fail, int'(masks[s] != 0));
      end
      total++;
      if (f_to !== 0) begin
        bad++;
        $display("FAIL s%0d_timeout got=%0d want=0", s, f_to);
      end
    end
  endtask

  task automatic test_watchdog();
    bit seen;
    drive_run(0, 1'b0, 1'b0, 20, 1);
    total++;
    if (m_launch !== 2 || m_cnt[0] !== 1) begin
      bad++;
      $display("FAIL wd_setup got=launch%0d/count%0d want=launch2/count1", m_launch, m_cnt[0]);
    end
`ifdef TXN_TIMEOUT_EN
    repeat (63) step();
    total++;
    if (bus.TIMEOUT !== 1'b0 || bus.BUSY !== 1'b1) begin
      bad++;
      $display("FAIL wd_early got=to%0b/busy%0b want=to0/busy1", bus.TIMEOUT, bus.BUSY);
    end
    step();
    total++;
    if (bus.TIMEOUT !== 1'b1 || bus.FAIL !== 1'b1) begin
      bad++;
      $display("FAIL wd_expiry got=to%0b/fail%0b want=to1/fail1", bus.TIMEOUT, bus.FAIL);
    end
    step();
    total++;
    if (bus.ALL_DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.TXN_COUNT !== CW'(1)) begin
      bad++;
      $display("FAIL wd_finish got=all%0b/busy%0b/count%0d want=all1/busy0/count1",
               bus.ALL_DONE, bus.BUSY, bus.TXN_COUNT);
    end
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.INIT_AXI_TXN) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL wd_no_relaunch got=%0b want=0", seen);
    end
`else
    seen = 1'b0;
    repeat (300) begin
      step();
      if (bus.INIT_AXI_TXN || bus.TIMEOUT || bus.ALL_DONE) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus.BUSY !== 1'b1 || bus.TXN_COUNT !== CW'(1)) begin
      bad++;
      $display("FAIL wait_forever got=event%0b/busy%0b/count%0d want=event0/busy1/count1",
               seen, bus.BUSY, bus.TXN_COUNT);
    end
    AXI_ARESETN = 1'b0;
    repeat (2) step();
    #2 AXI_ARESETN = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_midrun();
    int budget;
    logic [CW+4:0] outs;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    budget = 8;
    while (bus.INIT_AXI_TXN && budget > 0) begin
      step();
      budget--;
    end
    repeat (10) step();
    bus.TXN_DONE = 1'b1;
    step();
    bus.TXN_DONE = 1'b0;
    budget = GAP + 8;
    while (!bus.INIT_AXI_TXN && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (bus.INIT_AXI_TXN !== 1'b1) begin
      bad++;
      $display("FAIL midrun_second_launch got=%0b want=1", bus.INIT_AXI_TXN);
    end
    #2 AXI_ARESETN = 1'b0;
    #1;
    outs = {bus.INIT_AXI_TXN, bus.BUSY, bus.ALL_DONE, bus.FAIL, bus.TIMEOUT, bus.TXN_COUNT};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midrun_async_clear got=%h want=0", outs);
    end
    repeat (3) @(posedge AXI_ACLK);
    #3 AXI_ARESETN = 1'b1;
    step();
    drive_run(0, 1'b0, 1'b0, -1, -1);
    total++;
    if (m_launch !== NUM || f_cnt !== NUM || f_all !== 1 || f_fail !== 0 || f_busy !== 0) begin
      bad++;
      $display("FAIL rerun_after_reset got=launch%0d/count%0d/all%0d/fail%0d/busy%0d want=%0d/%0d/1/0/0",
               m_launch, f_cnt, f_all, f_fail, f_busy, NUM, NUM);
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_watchdog();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit got=expired want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
